mem_ctrl_banked: RTL and testbench
==================================

Name: mem_ctrl_banked

Overview:
Parametrised multi-bank successor of the single-bank memory controller. It accepts one host read/write request at a time over a valid/ready handshake and tracks an open row per bank (open-page policy). It issues ACT/READ/WRITE/PRE/PREALL/REFRESH commands with programmable timing, runs periodic refresh, and returns read data with a one-cycle valid pulse. It sits between the host request agent and the DRAM device model.

Parameters:
NUM_BANKS, 4, number of banks; power of two, >=2; BANK_W = log2(NUM_BANKS)
ROW_W, 4, row address width
COL_W, 12, column address width
DATA_W, 32, data width
T_RCD, 3, cycles from ACT to READ/WRITE; >=1
T_RP, 3, cycles from PRE/PREALL to the next command; >=1
T_CL, 2, cycles from READ command to dq_in sample; >=1
T_WR, 2, cycles from WRITE to the next command; >=1
T_REFI, 300, refresh interval in cycles; exceeds the worst-case single-op length
T_RFC, 5, cycles from REFRESH to IDLE; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_rdnwr  in  1  1=read, 0=write
req_addr  in  BANK_W+ROW_W+COL_W  {bank,row,col}
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle read-data-valid pulse
rsp_rdata  out  DATA_W  read data
command  out  3  NOP=000 ACT=001 READ=010 WRITE=011 PRE=100 REFRESH=101 PREALL=110
cs_n  out  1  low exactly when command != NOP
ba  out  BANK_W  bank address
ra  out  ROW_W  row address
ca  out  COL_W  column address
dq_out  out  DATA_W  write data to device
dq_oe  out  1  dq_out drive enable
dq_in  in  DATA_W  read data from device
refresh_pending  out  1  refresh requested, not yet issued

Behaviour:
- All outputs are registered. The clock is clk. Reset is rst: asynchronous and active-high.
- Reset: state IDLE, all banks closed, command NOP, cs_n=1, req_ready=0, rsp_valid=0, dq_oe=0, and ba/ra/ca/dq_out/rsp_rdata/refresh counter/refresh_pending all 0. req_ready rises on the first cycle after reset deasserts.
- Reset mid-operation: immediate return to IDLE, all banks closed, any in-flight read dropped (no rsp_valid).
- req_ready=1 only in IDLE with refresh_pending=0. A transfer occurs on req_valid&req_ready. Op, address and wdata are latched; req_ready drops the next cycle.
- States: IDLE, PRE, RP_WAIT, ACT, RCD_WAIT, RD, CL_WAIT, WR, WR_WAIT, PREALL, RFC_WAIT, REFRESH. Every command state lasts one cycle. Wait states load a counter with T_x-1 and drive NOP. They exit when the counter reaches 0, so the next command issues exactly T_x cycles after the previous one.
- Accepted request, with the first command on the cycle after acceptance:
  - Bank hit (bank open, same row): RD or WR directly.
  - Bank closed: ACT -> RCD_WAIT -> RD/WR.
  - Row conflict: PRE (ba = bank) -> RP_WAIT -> ACT -> RCD_WAIT -> RD/WR.
- Bank tracking: ACT marks the bank open with its row. PRE closes the bank. PREALL and REFRESH close all banks. Rows are never closed after an access.
- RD: command READ with ba/ra/ca. dq_in is sampled T_CL cycles later. rsp_valid is 1 for exactly one cycle, the cycle after sampling, with rsp_rdata = the sampled value. IDLE is re-entered on that same cycle.
- WR: command WRITE with dq_oe=1 and dq_out=wdata for that cycle only, then WR_WAIT for T_WR, then IDLE.
- ba/ra/ca hold their last value when command is NOP.
- Refresh:
  - The counter increments every cycle. On reaching T_REFI-1 it wraps to 0 and sets refresh_pending. A second expiry while pending leaves the flag set; nothing is counted twice.
  - In IDLE, refresh_pending has priority over req_valid. If both occur in the same cycle, the refresh runs and the request waits.
  - Sequence: PREALL -> RP_WAIT (only if any bank is open) -> REFRESH -> RFC_WAIT (T_RFC) -> IDLE.
  - refresh_pending clears on the cycle REFRESH issues.
  - An operation already in progress is never interrupted by refresh.

Test Plan:
- Reset: assert rst mid-read (during CL_WAIT) -> next cycle command=NOP, cs_n=1, rsp_valid never pulses, req_ready=1 after rst falls.
- Cold read, req_addr={0,4'h3,12'h010} accepted at c0 -> ACT c1, READ c4, dq_in sampled c6, rsp_valid=1 at c7 only, rsp_rdata = dq_in at c6.
- Hit then conflict:
  - Hit: read to bank0 row3 accepted at c0 -> READ at c1, rsp_valid at c4.
  - Conflict: read to bank0 row5 accepted at c0 -> PRE c1, ACT c4, READ c7, rsp_valid c10.
- Write hit: wdata=32'hDEADBEEF accepted at c0 -> WRITE with dq_oe=1 and dq_out=32'hDEADBEEF at c1 only, req_ready=1 again at c3.
- Refresh: idle bench with bank2 open -> refresh_pending=1 after 300 cycles, then PREALL, REFRESH 3 cycles later, IDLE 5 cycles after that. A simultaneous req_valid is held off until then, and all banks are closed (the next access issues ACT).
- Multi-bank (NUM_BANKS=8, ROW_W=6): open rows in banks 0 and 7 -> alternating accesses to both are all hits (no PRE/ACT issued).

Source files
------------

// File: rtl/mem_ctrl_banked.sv
// mem_ctrl_banked: open-page multi-bank DRAM controller with programmable command timing
// and periodic refresh; accepts one host request at a time over a valid/ready handshake.
module mem_ctrl_banked #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 12,
    parameter int DATA_W    = 32,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_CL      = 2,
    parameter int T_WR      = 2,
    parameter int T_REFI    = 300,
    parameter int T_RFC     = 5,
    localparam int BANK_W   = $clog2(NUM_BANKS),
    localparam int ADDR_W   = BANK_W + ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rdnwr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [2:0]        command,
    output logic              cs_n,
    output logic [BANK_W-1:0] ba,
    output logic [ROW_W-1:0]  ra,
    output logic [COL_W-1:0]  ca,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_in,
    output logic              refresh_pending
);

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_ACT     = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_WRITE   = 3'b011;
    localparam logic [2:0] CMD_PRE     = 3'b100;
    localparam logic [2:0] CMD_REFRESH = 3'b101;
    localparam logic [2:0] CMD_PREALL  = 3'b110;

    localparam int CNT_W = 16;
    localparam int REF_W = $clog2(T_REFI);

    typedef enum logic [3:0] {
        IDLE, PRE, RP_WAIT, ACT, RCD_WAIT, RD, CL_WAIT,
        WR, WR_WAIT, PREALL, RFC_WAIT, REFRESH
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               in_ref, in_ref_next;
    logic               rsp_next;
    logic [2:0]         cmd_next;

    logic               lat_rdnwr;
    logic [BANK_W-1:0]  lat_bank;
    logic [ROW_W-1:0]   lat_row;
    logic [COL_W-1:0]   lat_col;
    logic [DATA_W-1:0]  lat_wdata;

    logic               cur_rdnwr;
    logic [BANK_W-1:0]  cur_bank;
    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   cur_col;
    logic [DATA_W-1:0]  cur_wdata;

    logic [NUM_BANKS-1:0] open_valid;
    logic [ROW_W-1:0]     open_row [NUM_BANKS];

    logic [REF_W-1:0]   ref_cnt;
    logic               ref_expire;
    logic               pending_next;
    logic               accept;
    logic               hit;

    // In IDLE the decision is made on the live request; afterwards on the latched copy.
    assign cur_rdnwr  = (state == IDLE) ? req_rdnwr : lat_rdnwr;
    assign cur_bank   = (state == IDLE) ? req_addr[ADDR_W-1 -: BANK_W] : lat_bank;
    assign cur_row    = (state == IDLE) ? req_addr[COL_W +: ROW_W] : lat_row;
    assign cur_col    = (state == IDLE) ? req_addr[COL_W-1:0] : lat_col;
    assign cur_wdata  = (state == IDLE) ? req_wdata : lat_wdata;

    assign accept     = req_valid && req_ready;
    assign hit        = open_valid[cur_bank] && (open_row[cur_bank] == cur_row);
    assign ref_expire = (ref_cnt == REF_W'(T_REFI - 1));
    // A fresh expiry wins over the clear so no refresh interval is ever lost.
    assign pending_next = ref_expire || (refresh_pending && (state_next != REFRESH));

    always_comb begin
        state_next  = state;
        cnt_next    = (cnt == '0) ? '0 : cnt - 1'b1;
        in_ref_next = in_ref;
        rsp_next    = 1'b0;
        cmd_next    = CMD_NOP;

        case (state)
            IDLE: begin
                if (refresh_pending) begin
                    in_ref_next = 1'b1;
                    state_next  = (|open_valid) ? PREALL : REFRESH;
                end else if (accept) begin
                    if (hit)
                        state_next = cur_rdnwr ? RD : WR;
                    else if (open_valid[cur_bank])
                        state_next = PRE;
                    else
                        state_next = ACT;
                end
            end
            PRE:      state_next = (T_RP == 1) ? ACT : RP_WAIT;
            PREALL:   state_next = (T_RP == 1) ? REFRESH : RP_WAIT;
            RP_WAIT:  if (cnt == '0) state_next = in_ref ? REFRESH : ACT;
            ACT:      state_next = (T_RCD == 1) ? (cur_rdnwr ? RD : WR) : RCD_WAIT;
            RCD_WAIT: if (cnt == '0) state_next = cur_rdnwr ? RD : WR;
            RD: begin
                state_next = CL_WAIT;
                cnt_next   = CNT_W'(T_CL - 1);
            end
            CL_WAIT: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    rsp_next   = 1'b1;
                end
            end
            WR:       state_next = (T_WR == 1) ? IDLE : WR_WAIT;
            WR_WAIT:  if (cnt == '0) state_next = IDLE;
            REFRESH: begin
                in_ref_next = 1'b0;
                state_next  = (T_RFC == 1) ? IDLE : RFC_WAIT;
            end
            RFC_WAIT: if (cnt == '0) state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // Command states never repeat, so entering one is where its following wait is timed.
        case (state_next)
            PRE:     begin cmd_next = CMD_PRE;     cnt_next = CNT_W'(T_RP - 1);  end
            PREALL:  begin cmd_next = CMD_PREALL;  cnt_next = CNT_W'(T_RP - 1);  end
            ACT:     begin cmd_next = CMD_ACT;     cnt_next = CNT_W'(T_RCD - 1); end
            RD:      cmd_next = CMD_READ;
            WR:      begin cmd_next = CMD_WRITE;   cnt_next = CNT_W'(T_WR - 1);  end
            REFRESH: begin cmd_next = CMD_REFRESH; cnt_next = CNT_W'(T_RFC - 1); end
            default: cmd_next = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            in_ref          <= 1'b0;
            lat_rdnwr       <= 1'b0;
            lat_bank        <= '0;
            lat_row         <= '0;
            lat_col         <= '0;
            lat_wdata       <= '0;
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
            req_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            command         <= CMD_NOP;
            cs_n            <= 1'b1;
            ba              <= '0;
            ra              <= '0;
            ca              <= '0;
            dq_out          <= '0;
            dq_oe           <= 1'b0;
            open_valid      <= '0;
            for (int i = 0; i < NUM_BANKS; i++) open_row[i] <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            in_ref          <= in_ref_next;
            ref_cnt         <= ref_expire ? '0 : ref_cnt + 1'b1;
            refresh_pending <= pending_next;
            req_ready       <= (state_next == IDLE) && !pending_next;
            rsp_valid       <= rsp_next;
            if (rsp_next) rsp_rdata <= dq_in;
            command         <= cmd_next;
            cs_n            <= (cmd_next == CMD_NOP);
            dq_oe           <= (state_next == WR);
            dq_out          <= (state_next == WR) ? cur_wdata : '0;
            if (accept) begin
                lat_rdnwr <= req_rdnwr;
                lat_bank  <= cur_bank;
                lat_row   <= cur_row;
                lat_col   <= cur_col;
                lat_wdata <= req_wdata;
            end
            case (state_next)
                PRE: begin
                    ba                   <= cur_bank;
                    open_valid[cur_bank] <= 1'b0;
                end
                ACT: begin
                    ba                   <= cur_bank;
                    ra                   <= cur_row;
                    open_valid[cur_bank] <= 1'b1;
                    open_row[cur_bank]   <= cur_row;
                end
                RD, WR: begin
                    ba <= cur_bank;
                    ra <= cur_row;
                    ca <= cur_col;
                end
                PREALL, REFRESH: open_valid <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_banked.sv
// tb_mem_ctrl_banked: directed self-checking bench for mem_ctrl_banked, covering a
// 4-bank default instance and an 8-bank / 6-bit-row instance.
module tb_mem_ctrl_banked;

    localparam logic [2:0] NOP = 3'b000, ACT = 3'b001, RDC = 3'b010, WRC = 3'b011;
    localparam logic [2:0] PRE = 3'b100, REF = 3'b101, PALL = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dq_in = '0;

    logic        req_valid = 0, req_rdnwr = 0, req_ready, rsp_valid, cs_n, dq_oe, refresh_pending;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0, rsp_rdata, dq_out;
    logic [2:0]  command;
    logic [1:0]  ba;
    logic [3:0]  ra;
    logic [11:0] ca;

    logic        req_valid_w = 0, req_rdnwr_w = 0, req_ready_w, rsp_valid_w, cs_n_w, dq_oe_w, pend_w;
    logic [20:0] req_addr_w = '0;
    logic [31:0] req_wdata_w = '0, rsp_rdata_w, dq_out_w;
    logic [2:0]  command_w;
    logic [2:0]  ba_w;
    logic [5:0]  ra_w;
    logic [11:0] ca_w;

    int check_count = 0;
    int fail_count  = 0;
    int since_reset = 0;

    logic [2:0]  tr_cmd   [32];
    logic        tr_rsp   [32];
    logic [31:0] tr_rdata [32];
    logic        tr_oe    [32];
    logic [31:0] tr_dout  [32];
    logic        tr_ready [32];
    logic        tr_pend  [32];
    logic [2:0]  tr_ba    [32];
    logic [5:0]  tr_ra    [32];
    logic [11:0] tr_ca    [32];

    mem_ctrl_banked dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rdnwr(req_rdnwr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .command(command), .cs_n(cs_n),
        .ba(ba), .ra(ra), .ca(ca), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .refresh_pending(refresh_pending)
    );

    mem_ctrl_banked #(.NUM_BANKS(8), .ROW_W(6)) dut_wide (
        .clk(clk), .rst(rst), .req_valid(req_valid_w), .req_ready(req_ready_w),
        .req_rdnwr(req_rdnwr_w), .req_addr(req_addr_w), .req_wdata(req_wdata_w),
        .rsp_valid(rsp_valid_w), .rsp_rdata(rsp_rdata_w), .command(command_w), .cs_n(cs_n_w),
        .ba(ba_w), .ra(ra_w), .ca(ca_w), .dq_out(dq_out_w), .dq_oe(dq_oe_w), .dq_in(dq_in),
        .refresh_pending(pend_w)
    );

    always #5 clk = ~clk;

    // Posedges seen with reset low; tracks the controller's refresh interval counter.
    always @(posedge clk) begin
        if (rst) since_reset <= 0;
        else     since_reset <= since_reset + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic sampleTrace(input int k, input bit wide);
        tr_cmd[k]   = wide ? command_w   : command;
        tr_rsp[k]   = wide ? rsp_valid_w : rsp_valid;
        tr_rdata[k] = wide ? rsp_rdata_w : rsp_rdata;
        tr_oe[k]    = wide ? dq_oe_w     : dq_oe;
        tr_dout[k]  = wide ? dq_out_w    : dq_out;
        tr_ready[k] = wide ? req_ready_w : req_ready;
        tr_pend[k]  = wide ? pend_w      : refresh_pending;
        tr_ba[k]    = wide ? ba_w        : {1'b0, ba};
        tr_ra[k]    = wide ? ra_w        : {2'b00, ra};
        tr_ca[k]    = wide ? ca_w        : ca;
    endtask

    // Called on a negedge; that cycle is c0. Traces c1..ncycles, dq_in = C0DE0000|cycle.
    task automatic applyStimulus(input bit wide, input bit rdnwr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ncycles);
        int guard = 0;
        while (!(wide ? req_ready_w : req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("ready_wait", 64'd0, 64'd1);
        dq_in = 32'hC0DE0000;
        if (wide) begin
            req_valid_w = 1; req_rdnwr_w = rdnwr; req_addr_w = addr[20:0]; req_wdata_w = wdata;
        end else begin
            req_valid = 1; req_rdnwr = rdnwr; req_addr = addr[17:0]; req_wdata = wdata;
        end
        for (int k = 1; k <= ncycles; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid   = 0;
                req_valid_w = 0;
            end
            sampleTrace(k, wide);
            dq_in = 32'hC0DE0000 | 32'(k);
        end
    endtask

    initial begin
        bit  seen_rsp;
        int  guard;

        // Reset values
        @(negedge clk);
        checkOutput("rst_cmd",   command, NOP);
        checkOutput("rst_cs_n",  cs_n, 1);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_rsp",   rsp_valid, 0);
        checkOutput("rst_oe",    dq_oe, 0);
        checkOutput("rst_addr",  {ba, ra, ca}, 0);
        checkOutput("rst_data",  {dq_out, rsp_rdata}, 0);
        checkOutput("rst_pend",  refresh_pending, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("ready_after_rst", req_ready, 1);

        // Cold read bank0 row3 col 0x010
        applyStimulus(0, 1, 32'({2'd0, 4'h3, 12'h010}), 0, 9);
        checkOutput("cold_act",     tr_cmd[1], ACT);
        checkOutput("cold_act_ra",  tr_ra[1], 3);
        checkOutput("cold_nop",     tr_cmd[2], NOP);
        checkOutput("cold_read",    tr_cmd[4], RDC);
        checkOutput("cold_read_ca", tr_ca[4], 12'h010);
        checkOutput("cold_rsp6",    tr_rsp[6], 0);
        checkOutput("cold_rsp7",    tr_rsp[7], 1);
        checkOutput("cold_rdata",   tr_rdata[7], 32'hC0DE0006);
        checkOutput("cold_rsp8",    tr_rsp[8], 0);
        checkOutput("cold_ready7",  tr_ready[7], 1);

        // Hit read bank0 row3
        applyStimulus(0, 1, 32'({2'd0, 4'h3, 12'h020}), 0, 6);
        checkOutput("hit_read",  tr_cmd[1], RDC);
        checkOutput("hit_ca",    tr_ca[1], 12'h020);
        checkOutput("hit_rsp3",  tr_rsp[3], 0);
        checkOutput("hit_rsp4",  tr_rsp[4], 1);
        checkOutput("hit_rdata", tr_rdata[4], 32'hC0DE0003);

        // Row conflict: bank0 row5
        applyStimulus(0, 1, 32'({2'd0, 4'h5, 12'h030}), 0, 12);
        checkOutput("conf_pre",    tr_cmd[1], PRE);
        checkOutput("conf_pre_ba", tr_ba[1], 0);
        checkOutput("conf_nop3",   tr_cmd[3], NOP);
        checkOutput("conf_act",    tr_cmd[4], ACT);
        checkOutput("conf_act_ra", tr_ra[4], 5);
        checkOutput("conf_read",   tr_cmd[7], RDC);
        checkOutput("conf_rsp9",   tr_rsp[9], 0);
        checkOutput("conf_rsp10",  tr_rsp[10], 1);
        checkOutput("conf_rdata",  tr_rdata[10], 32'hC0DE0009);

        // Write hit bank0 row5
        applyStimulus(0, 0, 32'({2'd0, 4'h5, 12'h007}), 32'hDEADBEEF, 4);
        checkOutput("wr_cmd",    tr_cmd[1], WRC);
        checkOutput("wr_oe1",    tr_oe[1], 1);
        checkOutput("wr_dout1",  tr_dout[1], 32'hDEADBEEF);
        checkOutput("wr_oe2",    tr_oe[2], 0);
        checkOutput("wr_ready2", tr_ready[2], 0);
        checkOutput("wr_ready3", tr_ready[3], 1);

        // Reset asserted during CL_WAIT of a hit read
        applyStimulus(0, 1, 32'({2'd0, 4'h5, 12'h001}), 0, 1);
        checkOutput("mid_read", tr_cmd[1], RDC);
        @(negedge clk);
        rst = 1;
        #1;
        checkOutput("mid_rst_cmd",  command, NOP);
        checkOutput("mid_rst_cs_n", cs_n, 1);
        seen_rsp = rsp_valid;
        @(negedge clk);
        seen_rsp |= rsp_valid;
        rst = 0;
        @(negedge clk);
        checkOutput("mid_rst_ready", req_ready, 1);
        for (int k = 0; k < 6; k++) begin
            seen_rsp |= rsp_valid;
            @(negedge clk);
        end
        checkOutput("mid_rst_no_rsp", seen_rsp, 0);

        // Banks closed by reset: write to bank2 row9 must activate
        applyStimulus(0, 0, 32'({2'd2, 4'h9, 12'h004}), 32'h12345678, 6);
        checkOutput("wr2_act",    tr_cmd[1], ACT);
        checkOutput("wr2_ba",     tr_ba[1], 2);
        checkOutput("wr2_write",  tr_cmd[4], WRC);
        checkOutput("wr2_dout",   tr_dout[4], 32'h12345678);
        checkOutput("wr2_ready5", tr_ready[5], 0);
        checkOutput("wr2_ready6", tr_ready[6], 1);

        // Refresh with bank2 open and a request held off
        guard = 0;
        while (!refresh_pending && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ref_onset", 64'(since_reset), 300);
        checkOutput("ref_ready0", req_ready, 0);
        req_valid = 1; req_rdnwr = 1; req_addr = {2'd2, 4'h9, 12'h005};
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            sampleTrace(k, 0);
            if (k == 10) req_valid = 0;
        end
        checkOutput("ref_preall",  tr_cmd[1], PALL);
        checkOutput("ref_pend3",   tr_pend[3], 1);
        checkOutput("ref_refresh", tr_cmd[4], REF);
        checkOutput("ref_pend4",   tr_pend[4], 0);
        checkOutput("ref_ready8",  tr_ready[8], 0);
        checkOutput("ref_ready9",  tr_ready[9], 1);
        checkOutput("ref_then_act", tr_cmd[10], ACT);
        repeat (12) @(negedge clk);

        // Eight banks, six-bit rows: banks 0 and 7 stay open across alternating accesses
        applyStimulus(1, 1, 32'({3'd0, 6'h2A, 12'h001}), 0, 8);
        checkOutput("w_b0_act",  tr_cmd[1], ACT);
        checkOutput("w_b0_ra",   tr_ra[1], 6'h2A);
        applyStimulus(1, 1, 32'({3'd7, 6'h15, 12'h002}), 0, 8);
        checkOutput("w_b7_act",  tr_cmd[1], ACT);
        checkOutput("w_b7_ba",   tr_ba[1], 7);
        applyStimulus(1, 1, 32'({3'd0, 6'h2A, 12'h003}), 0, 5);
        checkOutput("w_b0_hit",  tr_cmd[1], RDC);
        checkOutput("w_b0_hba",  tr_ba[1], 0);
        checkOutput("w_b0_rsp",  tr_rsp[4], 1);
        applyStimulus(1, 1, 32'({3'd7, 6'h15, 12'h004}), 0, 5);
        checkOutput("w_b7_hit",  tr_cmd[1], RDC);
        checkOutput("w_b7_hba",  tr_ba[1], 7);
        checkOutput("w_b7_hra",  tr_ra[1], 6'h15);
        applyStimulus(1, 0, 32'({3'd0, 6'h2A, 12'h005}), 32'hA5A5A5A5, 3);
        checkOutput("w_b0_wr",   tr_cmd[1], WRC);
        applyStimulus(1, 0, 32'({3'd7, 6'h15, 12'h006}), 32'h5A5A5A5A, 3);
        checkOutput("w_b7_wr",   tr_cmd[1], WRC);
        checkOutput("w_b7_dout", tr_dout[1], 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
